// File: rtl/led_pkg.sv
// Shared constants and types for the LED panel frame buffer.
// The gamma table is used only when LED_FB_GAMMA_EN is defined.
package led_pkg;

  localparam int LED_COLS          = 64;
  localparam int LED_HALF_ROWS     = 16;
  localparam int LED_PIX_PER_FRAME = 2048;

  typedef enum logic [1:0] {
    FB_IDLE,
    FB_FILL,
    FB_PEND
  } fb_state_e;

  // Entry i sits at bits [4*i+3 : 4*i].
  localparam logic [63:0] LED_GAMMA_LUT = {
    4'd15, 4'd11, 4'd9, 4'd7, 4'd5, 4'd4, 4'd3, 4'd2,
    4'd2,  4'd1,  4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0
  };

  function automatic logic [11:0] led_gamma(input logic [11:0] rgb);
    return {LED_GAMMA_LUT[{rgb[11:8], 2'b00} +: 4],
            LED_GAMMA_LUT[{rgb[7:4],  2'b00} +: 4],
            LED_GAMMA_LUT[{rgb[3:0],  2'b00} +: 4]};
  endfunction

endpackage

// File: rtl/led_fb_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register clears on reset; the array contents do not.
module led_fb_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; clearing it would need a sweep.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: non-blocking assignment keeps every register updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered pixel store for the 64x32 LED panel; swaps only at the driver frame boundary.
// Define LED_FB_GAMMA_EN to pass each colour channel through the gamma table before storage.
module led_frame_buffer
  import led_pkg::*;
#(
  parameter int COLS      = LED_COLS,
  parameter int HALF_ROWS = LED_HALF_ROWS
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          wr_valid,
  output logic                                          wr_ready,
  input  logic                                          wr_sof,
  input  logic [11:0]                                   wr_data,
  input  logic [$clog2(HALF_ROWS)+$clog2(COLS)-1:0]     rd_addr,
  output logic [23:0]                                   rd_data,
  input  logic                                          rd_frame_start,
  output logic                                          swap_done,
  output logic                                          frame_err
);

  localparam int HALF_W = $clog2(HALF_ROWS) + $clog2(COLS);
  localparam int PIX_W  = HALF_W + 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(2 * COLS * HALF_ROWS - 1);

  fb_state_e        state, state_next;
  logic [PIX_W-1:0] pix_cnt, cnt_next, wr_pix;
  logic             front_sel, toggle, err_next, we;
  logic             accept;
  logic [11:0]      wdata, lo_q, hi_q;

  assign accept = wr_valid && wr_ready;

`ifdef LED_FB_GAMMA_EN
  assign wdata = led_gamma(wr_data);
`else
  assign wdata = wr_data;
`endif

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = pix_cnt;
    wr_pix     = '0;
    we         = 1'b0;
    toggle     = 1'b0;
    err_next   = 1'b0;
    case (state)
      FB_IDLE: begin
        if (accept && wr_sof) begin
          we         = 1'b1;
          cnt_next   = PIX_W'(1);
          state_next = FB_FILL;
        end
      end
      FB_FILL: begin
        if (accept) begin
          we = 1'b1;
          if (wr_sof) begin
            cnt_next = PIX_W'(1);
            err_next = 1'b1;
          end else begin
            wr_pix   = pix_cnt;
            cnt_next = pix_cnt + 1'b1;
            if (pix_cnt == PIX_LAST) state_next = FB_PEND;
          end
        end
      end
      FB_PEND: begin
        if (rd_frame_start) begin
          toggle     = 1'b1;
          state_next = FB_IDLE;
        end
      end
      default: state_next = FB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FB_IDLE;
      pix_cnt   <= '0;
      front_sel <= 1'b0;
      wr_ready  <= 1'b0;
      swap_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      pix_cnt   <= cnt_next;
      front_sel <= front_sel ^ toggle;
      wr_ready  <= (state_next != FB_PEND);
      swap_done <= toggle;
      frame_err <= err_next;
    end
  end

  // Pixel MSB picks the half: rows 0..HALF_ROWS-1 go low, the rest go high.
  led_fb_ram #(.DATA_W(12), .ADDR_W(PIX_W)) u_ram_lo (
    .clk   (clk),
    .rst   (rst),
    .we    (we && !rst && !wr_pix[PIX_W-1]),
    .waddr ({~front_sel, wr_pix[HALF_W-1:0]}),
    .wdata (wdata),
    .raddr ({front_sel, rd_addr}),
    .rdata (lo_q)
  );

  led_fb_ram #(.DATA_W(12), .ADDR_W(PIX_W)) u_ram_hi (
    .clk   (clk),
    .rst   (rst),
    .we    (we && !rst && wr_pix[PIX_W-1]),
    .waddr ({~front_sel, wr_pix[HALF_W-1:0]}),
    .wdata (wdata),
    .raddr ({front_sel, rd_addr}),
    .rdata (hi_q)
  );

  assign rd_data = {hi_q, lo_q};

endmodule

// File: tb/tb_led_frame_buffer.sv
// Scoreboard bench for led_frame_buffer: a frame-level model predicts each cycle's outputs.
// Compile with LED_FB_GAMMA_EN defined on both files to cover the gamma path.
module tb_led_frame_buffer;

  logic        clk = 1'b0;
  logic        rst, wr_valid, wr_ready, wr_sof, rd_frame_start, swap_done, frame_err;
  logic [11:0] wr_data;
  logic [9:0]  rd_addr;
  logic [23:0] rd_data;

  led_frame_buffer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sof(wr_sof),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_frame_start(rd_frame_start), .swap_done(swap_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        swap;
    logic        err;
    logic        rd_chk;
    logic [23:0] rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Frame-level reference: buffers indexed by raster pixel number (row*64 + col).
  logic [11:0] m_mem   [2][2048];
  bit          m_known [2][2048];
  bit          m_front, m_filling, m_pend, m_ready;
  int          m_next;

  function automatic logic [11:0] ref_gamma(input logic [11:0] d);
`ifdef LED_FB_GAMMA_EN
    int lut [16] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 7, 9, 11, 15};
    return {4'(lut[d[11:8]]), 4'(lut[d[7:4]]), 4'(lut[d[3:0]])};
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic m_write(input int p, input logic [11:0] d);
    m_mem[~m_front][p]   = ref_gamma(d);
    m_known[~m_front][p] = 1'b1;
  endtask

  // Drive one clock cycle, advance the model, queue the outputs expected after the edge.
  task automatic cyc(input bit r, input bit v, input bit s, input logic [11:0] d,
                     input bit fs, input bit rq, input logic [9:0] ra);
    exp_t e;
    int   lo_i, hi_i;
    bit   acc;
    e = '0;
    rst = r; wr_valid = v; wr_sof = s; wr_data = d; rd_frame_start = fs; rd_addr = ra;
    if (rq) begin
      lo_i = int'(ra[9:6]) * 64 + int'(ra[5:0]);
      hi_i = lo_i + 1024;
      if (r) begin
        e.rd_chk = 1'b1;
        e.rd     = '0;
      end else if (m_known[m_front][lo_i] && m_known[m_front][hi_i]) begin
        e.rd_chk = 1'b1;
        e.rd     = {m_mem[m_front][hi_i], m_mem[m_front][lo_i]};
      end
    end
    if (r) begin
      m_front = 0; m_filling = 0; m_pend = 0; m_ready = 0; m_next = 0;
    end else begin
      acc = v && m_ready;
      if (m_pend) begin
        if (fs) begin
          m_front = ~m_front;
          m_pend  = 0;
          e.swap  = 1'b1;
        end
      end else if (acc) begin
        if (s) begin
          e.err     = m_filling;
          m_write(0, d);
          m_next    = 1;
          m_filling = 1;
        end else if (m_filling) begin
          m_write(m_next, d);
          m_next++;
          if (m_next == 2048) begin
            m_filling = 0;
            m_pend    = 1;
          end
        end
      end
      m_ready = !m_pend;
    end
    e.ready = m_ready;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit fs_last);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 12'h0, fs_last && (i == n - 1), $urandom_range(0, 1) == 1, 10'($urandom));
  endtask

  // Push n accepted beats with random gaps; mode 0 data = beat index, mode 1 random.
  task automatic send_beats(input int n, input int mode, input bit first_sof,
                            input bit fs_on_last, input bit f84_first);
    int          k = 0;
    int          budget = 8 * n + 100;
    bit          v, s, fs;
    logic [11:0] d;
    while (k < n && budget > 0) begin
      budget--;
      v  = ($urandom_range(0, 3) != 0);
      s  = first_sof && (k == 0);
      d  = (mode == 0) ? 12'(k) : 12'($urandom);
      if (f84_first && k == 0) d = 12'hF84;
      fs = fs_on_last && v && (k == n - 1);
      if (!fs && $urandom_range(0, 63) == 0) fs = 1'b1;
      if (v && m_ready) k++;
      cyc(0, v, s, d, fs, $urandom_range(0, 1) == 1, 10'($urandom));
    end
    if (budget == 0) check("beat_budget", 32'(k), 32'(n));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("wr_ready", 32'(wr_ready), 32'(mon_e.ready));
      check("swap_done", 32'(swap_done), 32'(mon_e.swap));
      check("frame_err", 32'(frame_err), 32'(mon_e.err));
      if (mon_e.rd_chk) check("rd_data", 32'(rd_data), 32'(mon_e.rd));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_front = 0; m_filling = 0; m_pend = 0; m_ready = 0; m_next = 0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 12'h0, 0, 1, 10'($urandom));
    idle(2, 0);
    // Beats without sof while idle are dropped.
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 12'($urandom), 0, 1, 10'($urandom));

    // Frame of pixel indices, then swap and corner reads.
    send_beats(2048, 0, 1, 0, 0);
    idle(3, 0);
    idle(1, 1);
    cyc(0, 0, 0, 12'h0, 0, 1, 10'h000);
    cyc(0, 0, 0, 12'h0, 0, 1, 10'h3FF);
    idle(30, 0);

    // Random frame held pending for 100 cycles under constant offers.
    send_beats(2048, 1, 1, 0, 1);
    for (int i = 0; i < 100; i++)
      cyc(0, 1, $urandom_range(0, 1) == 1, 12'($urandom), 0, 1, 10'($urandom));
    idle(1, 1);
    cyc(0, 0, 0, 12'h0, 0, 1, 10'h000);
    idle(20, 0);

    // Aborted frame, restart, last beat coincides with frame start.
    send_beats(500, 1, 1, 0, 0);
    send_beats(2048, 1, 1, 1, 0);
    idle(5, 0);
    idle(1, 1);
    idle(30, 0);

    // Reset in the middle of a frame, then a clean frame afterwards.
    send_beats(300, 1, 1, 0, 0);
    cyc(1, 0, 0, 12'h0, 0, 1, 10'($urandom));
    cyc(1, 0, 0, 12'h0, 0, 0, 10'h0);
    idle(40, 0);
    send_beats(2048, 1, 1, 0, 0);
    idle(2, 1);
    idle(30, 0);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
